// File: rtl/hps_restart_pkg.sv
// Shared opcodes, command payload, FSM state type and sizing helper for the HPS restart sequencer.
package hps_restart_pkg;

  localparam int unsigned CMD_W    = 8;
  localparam int unsigned ARG_W    = 6;
  localparam int unsigned CH_IDX_W = 6;
  localparam int unsigned RCNT_W   = 8;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_ARM   = 2'b01;
  localparam logic [1:0] OP_FIRE  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [ARG_W-1:0] ARM_KEY_DEFAULT = 6'h2A;

  typedef struct packed {
    logic [1:0]       op;
    logic [ARG_W-1:0] arg;
  } hps_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PULSE,
    ST_COOLDOWN
  } restart_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hps_restart_if.sv
// HPS-facing command/status bundle of the restart sequencer.
interface hps_restart_if #(
  parameter int unsigned NUM_CH = 4
);

  logic [7:0]        hps_reset_export;
  logic [NUM_CH-1:0] hps_restart;
  logic              busy;
  logic              armed;
  logic              cmd_err;
  logic [5:0]        last_ch;
  logic [7:0]        restart_cnt;

  modport master (
    output hps_reset_export,
    input  hps_restart,
    input  busy,
    input  armed,
    input  cmd_err,
    input  last_ch,
    input  restart_cnt
  );

  modport slave (
    input  hps_reset_export,
    output hps_restart,
    output busy,
    output armed,
    output cmd_err,
    output last_ch,
    output restart_cnt
  );

endinterface

// File: rtl/hps_restart_sequencer_cmd_edge_detect.sv
// Turns a change of the PIO command byte into a one-cycle registered command strobe.
module hps_cmd_edge_detect
  import hps_restart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] cmd_in,
  output logic             cmd_valid,
  output hps_cmd_t         cmd
);

  logic [CMD_W-1:0] cmd_q;

  // Any difference from the previous sample is a new command, NOP included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q     <= '0;
      cmd_valid <= 1'b0;
      cmd       <= '0;
    end else begin
      cmd_q     <= cmd_in;
      cmd_valid <= (cmd_in != cmd_q);
      cmd       <= hps_cmd_t'(cmd_in);
    end
  end

endmodule

// File: rtl/hps_restart_sequencer.sv
// ARM/FIRE guarded restart pulse generator with busy/error/count readback.
// Optional: define HPS_RESTART_ARM_TIMEOUT_EN to auto-disarm after ARM_TIMEOUT cycles.
module hps_restart_sequencer
  import hps_restart_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned PULSE_CYCLES    = 16,
  parameter int unsigned COOLDOWN_CYCLES = 64,
  parameter logic [5:0]  ARM_KEY         = ARM_KEY_DEFAULT,
  parameter int unsigned ARM_TIMEOUT     = 1024
) (
  input  logic          clk,
  input  logic          reset,
  hps_restart_if.slave  bus
);

  localparam int unsigned CNT_W =
    $clog2(max3(PULSE_CYCLES, COOLDOWN_CYCLES, ARM_TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARM_LOAD   = CNT_W'(ARM_TIMEOUT - 1);

  logic     cmd_valid;
  hps_cmd_t cmd;

  hps_cmd_edge_detect u_edge (
    .clk       (clk),
    .reset     (reset),
    .cmd_in    (bus.hps_reset_export),
    .cmd_valid (cmd_valid),
    .cmd       (cmd)
  );

  restart_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [CH_IDX_W-1:0]  last_ch_q, last_ch_d;
  logic [RCNT_W-1:0]    rcnt_q, rcnt_d;
  logic [NUM_CH-1:0]    hr_q, hr_d;
  logic                 busy_q, busy_d;
  logic                 armed_q, armed_d;
  logic                 cmd_live;
  logic                 fire_ok;

  assign cmd_live = cmd_valid && (cmd.op != OP_NOP);
  assign fire_ok  = ({1'b0, cmd.arg} < 7'(NUM_CH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      last_ch_q <= '0;
      rcnt_q    <= '0;
      hr_q      <= '0;
      busy_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      last_ch_q <= last_ch_d;
      rcnt_q    <= rcnt_d;
      hr_q      <= hr_d;
      busy_q    <= busy_d;
      armed_q   <= armed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    last_ch_d = last_ch_q;
    rcnt_d    = rcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_live) begin
          case (cmd.op)
            OP_ARM: begin
              if (cmd.arg == ARM_KEY) begin
                state_d = ST_ARMED;
                cnt_d   = ARM_LOAD;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_FIRE:  err_d = 1'b1;
            OP_CLEAR: err_d = 1'b0;
            default:  ;
          endcase
        end
      end

      ST_ARMED: begin
        if (cmd_live) begin
          case (cmd.op)
            OP_FIRE: begin
              if (fire_ok) begin
                state_d   = ST_PULSE;
                cnt_d     = PULSE_LOAD;
                last_ch_d = cmd.arg;
                rcnt_d    = rcnt_q + 8'd1;
              end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
              end
            end
            OP_CLEAR: begin
              state_d = ST_IDLE;
              err_d   = 1'b0;
            end
            // Re-arm restarts the timeout; a bad key while armed drops the arming.
            OP_ARM: begin
              if (cmd.arg == ARM_KEY) begin
                cnt_d = ARM_LOAD;
              end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
              end
            end
            default: ;
          endcase
        end
`ifdef HPS_RESTART_ARM_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
      end

      ST_PULSE: begin
        if (cmd_live) err_d = 1'b1;
        if (cnt_q == '0) begin
          if (COOLDOWN_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COOLDOWN;
            cnt_d   = COOL_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_COOLDOWN: begin
        if (cmd_live) err_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they track it exactly.
    hr_d    = (state_d == ST_PULSE) ? (NUM_CH'(1) << last_ch_d) : '0;
    busy_d  = (state_d == ST_PULSE) || (state_d == ST_COOLDOWN);
    armed_d = (state_d == ST_ARMED);
  end

  assign bus.hps_restart = hr_q;
  assign bus.busy        = busy_q;
  assign bus.armed       = armed_q;
  assign bus.cmd_err     = err_q;
  assign bus.last_ch     = last_ch_q;
  assign bus.restart_cnt = rcnt_q;

endmodule

// File: doc/hps_restart_sequencer.md
# hps_restart_sequencer

Parametrised restart controller driven by the HPS through a PIO command byte. It generates timed, per-channel restart pulses for fabric subsystems such as filter engines and MAC/PCS blocks. A two-step ARM/FIRE protocol guards against spurious restarts, and busy/error/count status is returned for HPS readback. It sits between the HPS PIO export and the reset inputs of the top-level fabric subsystems.

## Interface
- NUM_CH, 4: number of restart channels (1..64)
- PULSE_CYCLES, 16: restart pulse width in clk cycles (≥1)
- COOLDOWN_CYCLES, 64: lockout after a pulse before new commands are accepted (≥0)
- ARM_KEY, 6'h2A: key required in the ARM command
- ARM_TIMEOUT, 1024: cycles ARMED persists before auto-disarm (used only with macro)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hps_reset_export  in  8  command byte from HPS PIO; [7:6] opcode, [5:0] argument
- hps_restart  out  NUM_CH  per-channel restart, active-high
- busy  out  1  high in PULSE or COOLDOWN
- armed  out  1  high in ARMED
- cmd_err  out  1  sticky command error
- last_ch  out  6  channel index of the most recent FIRE
- restart_cnt  out  8  total pulses issued, wraps 255→0

## Operation
- Command detection: register cmd_q samples hps_reset_export every cycle. A command is the cycle where hps_reset_export != cmd_q. A repeated identical command needs an intervening different value; NOP is the intended separator. cmd_q resets to 8'h00.
- Opcodes: 00 NOP; 01 ARM (arg must equal ARM_KEY); 10 FIRE (arg = channel index); 11 CLEAR.
- FSM states: IDLE, ARMED, PULSE, COOLDOWN. Reset state is IDLE.
- IDLE:
  - ARM with correct key → ARMED.
  - ARM with wrong key, or FIRE → cmd_err=1, stay IDLE.
  - CLEAR → cmd_err=0.
- ARMED:
  - FIRE with arg < NUM_CH → PULSE; latch last_ch=arg.
  - FIRE with arg ≥ NUM_CH → cmd_err=1, go to IDLE.
  - CLEAR → IDLE and cmd_err=0.
  - ARM → stay ARMED, timeout restarts.
- PULSE: hps_restart[last_ch]=1 for exactly PULSE_CYCLES cycles, then COOLDOWN. restart_cnt increments once on PULSE entry.
- COOLDOWN: lasts COOLDOWN_CYCLES cycles, then IDLE. If COOLDOWN_CYCLES=0, PULSE goes directly to IDLE.
- Commands arriving in PULSE or COOLDOWN, CLEAR included, are discarded and set cmd_err=1. cmd_q keeps tracking the input, so these commands are lost, not queued.
- Only one channel is ever asserted. hps_restart is one-hot or zero.
- Reset values: hps_restart=0, busy=0, armed=0, cmd_err=0, last_ch=0, restart_cnt=0. Reset mid-pulse deasserts hps_restart immediately (asynchronous).
- Counter width is clog2(max(PULSE_CYCLES, COOLDOWN_CYCLES, ARM_TIMEOUT)+1), shared between states.

## Timing
- Command visible first at edge t (input != cmd_q) → the state change and all outputs are registered at edge t+1. Latency is 1 cycle.
- FIRE accepted at edge t+1 → hps_restart high during cycles t+1 .. t+PULSE_CYCLES. busy is high from t+1 to the end of COOLDOWN.
- busy, armed, and hps_restart are all driven straight from the state/counter registers, with no combinational path from the input.
- A command on the last COOLDOWN cycle is discarded (cmd_err=1). The first acceptable command is the one detected while in IDLE.

## Configuration
- HPS_RESTART_ARM_TIMEOUT_EN defined: ARMED returns to IDLE after ARM_TIMEOUT cycles without a FIRE, and sets cmd_err=1.
- HPS_RESTART_ARM_TIMEOUT_EN undefined: ARMED persists indefinitely, and the ARM_TIMEOUT parameter is ignored.

## Structure
- Package hps_restart_pkg holds:
  - opcode constants OP_NOP, OP_ARM, OP_FIRE, OP_CLEAR
  - the state enum typedef restart_state_t
  - default ARM_KEY
- Sub-module hps_cmd_edge_detect holds cmd_q and emits a one-cycle cmd_valid plus opcode/arg. The FSM stays in hps_restart_sequencer.

## Test plan
- Reset, then ARM 0x6A, NOP 0x00, FIRE 0x82 → hps_restart=4'b0100 for 16 cycles; busy high for 80 cycles; restart_cnt=1; last_ch=2.
- FIRE 0x81 from IDLE → no pulse, cmd_err=1. Then CLEAR 0xC0 → cmd_err=0.
- ARM with wrong key 0x55 → cmd_err=1, armed=0. ARM 0x6A, then FIRE 0x87 with NUM_CH=4 → cmd_err=1, state IDLE, no pulse.
- ARM/FIRE ch0, then ARM 0x6A during COOLDOWN → ignored with cmd_err=1. After cooldown, ARM/FIRE again → restart_cnt=2.
- Assert reset at pulse cycle 5 → hps_restart=0 immediately; all outputs return to reset values. A post-reset ARM/FIRE works normally.
- With HPS_RESTART_ARM_TIMEOUT_EN and ARM_TIMEOUT=10: ARM then wait 10 cycles → armed=0, cmd_err=1, and a subsequent FIRE gives no pulse. Without the macro, armed stays high after 2000 cycles.
